uart_tx_arbiter: RTL and testbench

Round-robin scheduler sharing one `uart_transceiver` between `N_REQ` byte producers. Accepts a frame from one requester at a time and launches it with a one-cycle `en_i` pulse. Tracks the transceiver's `ready_o` through start and completion, then reports per-requester completion. Sits directly in front of `uart_transceiver`; requesters never drive the transceiver themselves.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_rr_picker.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 130 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and width helpers for the UART TX arbiter and related schedulers.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LAUNCH     = 2'd1,
        WAIT_START = 2'd2,
        WAIT_DONE  = 2'd3
    } arb_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_width(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: first asserted request at or above ptr, modulo N_REQ.
module uart_rr_picker
    import uart_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IW    = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic             any,
    output logic [IW-1:0]    winner
);

    int idx;

    // Scanning downward lets the candidate closest to ptr overwrite the others.
    always_comb begin
        any    = 1'b0;
        winner = '0;
        idx    = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (req[idx]) begin
                any    = 1'b1;
                winner = idx[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among N_REQ byte producers.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// IDLE       | waiting for a valid requester while the transmitter is ready
// LAUNCH     | one-cycle en pulse to transmitter, accept pulse to winner
// WAIT_START | waiting for transmitter ready to fall; times out to IDLE
// WAIT_DONE  | frame on the line; ready rising ends it with a done pulse
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int DATA_AMOUNT = 8,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                         clk_i,
    input  logic                         arst_i,
    input  logic [N_REQ-1:0]             req_valid_i,
    input  logic [N_REQ*DATA_AMOUNT-1:0] req_data_i,
    output logic [N_REQ-1:0]             req_ready_o,
    output logic [N_REQ-1:0]             done_o,
    output logic                         err_o,
    output logic                         busy_o,
    output logic [$clog2(N_REQ)-1:0]     gnt_id_o,
    output logic                         uart_en_o,
    output logic [DATA_AMOUNT-1:0]       uart_data_o,
    input  logic                         uart_ready_i
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = cnt_width(ACK_TIMEOUT);

    arb_state_t             state_q, state_d;
    logic [IW-1:0]          ptr_q, ptr_d;
    logic [IW-1:0]          gnt_q, gnt_d;
    logic [DATA_AMOUNT-1:0] data_q, data_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [N_REQ-1:0]       done_q, done_d;
    logic                   err_q, err_d;

    logic                   pick_any;
    logic [IW-1:0]          pick_winner;

    uart_rr_picker #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_picker (
        .req    (req_valid_i),
        .ptr    (ptr_q),
        .any    (pick_any),
        .winner (pick_winner)
    );

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        done_d  = '0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any && uart_ready_i) begin
                    data_d  = req_data_i[pick_winner*DATA_AMOUNT +: DATA_AMOUNT];
                    gnt_d   = pick_winner;
                    ptr_d   = (pick_winner == IW'(N_REQ - 1)) ? '0 : pick_winner + 1'b1;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                cnt_d   = '0;
                state_d = WAIT_START;
            end
            WAIT_START: begin
                // Counter holds cycles already spent here, so the last one ends at ACK_TIMEOUT-1.
                if (!uart_ready_i) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (uart_ready_i) begin
                    done_d[gnt_q] = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = '0;
        if (state_q == LAUNCH) begin
            req_ready_o[gnt_q] = 1'b1;
        end
    end

    assign uart_en_o   = (state_q == LAUNCH);
    assign busy_o      = (state_q != IDLE);
    assign gnt_id_o    = gnt_q;
    assign uart_data_o = data_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple transmitter ready model.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int TO = 16;
    localparam int M_DROP = 3;
    localparam int M_LEN  = 20;

    logic           clk = 1'b0;
    logic           arst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   done;
    logic           err;
    logic           busy;
    logic [1:0]     gnt_id;
    logic           uart_en;
    logic [DW-1:0]  uart_data;
    logic           uart_ready;

    bit   model_on = 1'b1;
    bit   model_stuck = 1'b0;
    logic model_ready = 1'b1;
    logic man_ready = 1'b1;
    bit   m_active = 1'b0;
    int   m_cnt = 0;

    int errors = 0;
    int checks = 0;

    assign uart_ready = model_on ? model_ready : man_ready;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N_REQ       (N),
        .DATA_AMOUNT (DW),
        .ACK_TIMEOUT (TO)
    ) dut (
        .clk_i        (clk),
        .arst_i       (arst),
        .req_valid_i  (req_valid),
        .req_data_i   (req_data),
        .req_ready_o  (req_ready),
        .done_o       (done),
        .err_o        (err),
        .busy_o       (busy),
        .gnt_id_o     (gnt_id),
        .uart_en_o    (uart_en),
        .uart_data_o  (uart_data),
        .uart_ready_i (uart_ready)
    );

    // Transmitter: ready falls M_DROP cycles after en, frame lasts M_LEN cycles.
    always @(posedge clk) begin
        #1;
        if (uart_en) begin
            m_active = 1'b1;
            m_cnt    = 0;
        end else if (m_active) begin
            m_cnt++;
            if (m_cnt >= M_DROP + M_LEN) m_active = 1'b0;
        end
        model_ready = model_stuck || !(m_active && m_cnt >= M_DROP);
    end

    task automatic do_reset();
        @(negedge clk);
        arst = 1'b1;
        req_valid = '0;
        @(negedge clk);
        arst = 1'b0;
    endtask

    task automatic wait_en(input int max_cyc, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            if (uart_en) seen = 1'b1;
        end
    endtask

    task automatic wait_done(input int max_cyc, output logic [N-1:0] val);
        val = '0;
        for (int i = 0; i < max_cyc && val == '0; i++) begin
            @(negedge clk);
            if (done != '0) val = done;
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({req_ready, done, err, busy, gnt_id, uart_en, uart_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {req_ready, done, err, busy, gnt_id, uart_en, uart_data});
        end
        @(negedge clk);
        arst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        bit seen;
        logic [N-1:0] d;
        req_data[2*DW +: DW] = 8'h72;
        req_valid = 4'b0100;
        wait_en(10, seen);
        checks++;
        if (!seen) begin errors++; $display("FAIL single_en: got none expected pulse"); end
        checks++;
        if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b expected 0100", req_ready); end
        checks++;
        if (uart_data !== 8'h72) begin errors++; $display("FAIL single_data: got %h expected 72", uart_data); end
        checks++;
        if (gnt_id !== 2'd2) begin errors++; $display("FAIL single_gnt: got %0d expected 2", gnt_id); end
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (uart_en !== 1'b0) begin errors++; $display("FAIL single_en_width: got %b expected 0", uart_en); end
        wait_done(60, d);
        checks++;
        if (d !== 4'b0100) begin errors++; $display("FAIL single_done: got %b expected 0100", d); end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_round_robin();
        int exp_g [5] = '{0, 1, 2, 3, 0};
        logic [1:0]    gq [5];
        logic [DW-1:0] dq [5];
        logic [N-1:0]  dn [5];
        int g = 0;
        int d = 0;
        do_reset();
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'(8'hA0 + i);
        req_valid = 4'b1111;
        for (int cyc = 0; cyc < 400 && d < 5; cyc++) begin
            @(negedge clk);
            if (uart_en) begin
                if (g < 5) begin gq[g] = gnt_id; dq[g] = uart_data; end
                g++;
                if (g == 5) req_valid = '0;
            end
            if (done != '0) begin
                if (d < 5) dn[d] = done;
                d++;
            end
        end
        checks++;
        if (g != 5 || d != 5) begin
            errors++;
            $display("FAIL rr_counts: got grants=%0d dones=%0d expected 5/5", g, d);
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (gq[k] !== 2'(exp_g[k])) begin
                    errors++; $display("FAIL rr_gnt[%0d]: got %0d expected %0d", k, gq[k], exp_g[k]);
                end
                checks++;
                if (dq[k] !== DW'(8'hA0 + exp_g[k])) begin
                    errors++; $display("FAIL rr_data[%0d]: got %h expected %h", k, dq[k], 8'hA0 + exp_g[k]);
                end
                checks++;
                if (dn[k] !== (4'b0001 << exp_g[k])) begin
                    errors++; $display("FAIL rr_done[%0d]: got %b expected %b", k, dn[k], 4'b0001 << exp_g[k]);
                end
            end
        end
    endtask

    task automatic test_wrap_skip();
        bit seen;
        logic [N-1:0] dv;
        do_reset();
        req_valid = 4'b0100;
        wait_en(10, seen);
        req_valid = '0;
        wait_done(60, dv);
        req_valid = 4'b1001;
        wait_en(10, seen);
        checks++;
        if (!seen || gnt_id !== 2'd3) begin
            errors++; $display("FAIL wrap_first: got %0d seen=%0d expected 3", gnt_id, seen);
        end
        req_valid = 4'b0001;
        wait_en(60, seen);
        checks++;
        if (!seen || gnt_id !== 2'd0 || req_ready !== 4'b0001) begin
            errors++; $display("FAIL wrap_second: got %0d ready=%b expected 0 ready=0001", gnt_id, req_ready);
        end
        req_valid = '0;
        wait_done(60, dv);
    endtask

    task automatic test_timeout();
        bit seen;
        logic [N-1:0] dv;
        int first_err = -1;
        bit any_done = 1'b0;
        bit busy_at_err = 1'b1;
        model_stuck = 1'b1;
        req_data[0 +: DW] = 8'h5C;
        req_valid = 4'b0001;
        wait_en(10, seen);
        req_valid = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (err && first_err < 0) begin first_err = k; busy_at_err = busy; end
            if (done != '0) any_done = 1'b1;
        end
        checks++;
        if (first_err != TO + 1) begin
            errors++; $display("FAIL timeout_cycle: got %0d expected %0d", first_err, TO + 1);
        end
        checks++;
        if (any_done) begin errors++; $display("FAIL timeout_no_done: got done pulse expected none"); end
        checks++;
        if (busy_at_err !== 1'b0) begin errors++; $display("FAIL timeout_idle: got busy=%b expected 0", busy_at_err); end
        model_stuck = 1'b0;
        req_data[1*DW +: DW] = 8'h3E;
        req_valid = 4'b0010;
        wait_en(60, seen);
        checks++;
        if (!seen || gnt_id !== 2'd1 || uart_data !== 8'h3E) begin
            errors++; $display("FAIL timeout_next: got gnt=%0d data=%h expected 1/3e", gnt_id, uart_data);
        end
        req_valid = '0;
        wait_done(60, dv);
        checks++;
        if (dv !== 4'b0010) begin errors++; $display("FAIL timeout_next_done: got %b expected 0010", dv); end
    endtask

    task automatic test_busy_xcvr();
        int en_cnt = 0;
        @(negedge clk);
        model_on  = 1'b0;
        man_ready = 1'b0;
        req_data[0 +: DW] = 8'h11;
        req_valid = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (uart_en || busy) en_cnt++;
        end
        checks++;
        if (en_cnt != 0) begin errors++; $display("FAIL busy_hold: got %0d active cycles expected 0", en_cnt); end
        man_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (uart_en !== 1'b1 || req_ready !== 4'b0001 || uart_data !== 8'h11) begin
            errors++; $display("FAIL busy_launch: got en=%b ready=%b data=%h expected 1/0001/11",
                               uart_en, req_ready, uart_data);
        end
        req_valid = '0;
        man_ready = 1'b0;
        repeat (3) @(negedge clk);
        man_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (done !== 4'b0001) begin errors++; $display("FAIL busy_done: got %b expected 0001", done); end
        model_on = 1'b1;
    endtask

    task automatic test_reset_mid_frame();
        bit seen;
        logic [N-1:0] dv;
        req_data[2*DW +: DW] = 8'h99;
        req_data[1*DW +: DW] = 8'h4D;
        req_valid = 4'b0100;
        wait_en(40, seen);
        req_valid = '0;
        repeat (6) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy: got %b expected 1", busy); end
        #2;
        arst = 1'b1;
        #1;
        checks++;
        if ({req_ready, done, err, busy, gnt_id, uart_en, uart_data} !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got %h expected 0",
                     {req_ready, done, err, busy, gnt_id, uart_en, uart_data});
        end
        @(negedge clk);
        req_valid = 4'b0110;
        arst = 1'b0;
        wait_en(60, seen);
        checks++;
        if (!seen || gnt_id !== 2'd1 || req_ready !== 4'b0010 || uart_data !== 8'h4D) begin
            errors++; $display("FAIL rst_mid_regrant: got gnt=%0d ready=%b data=%h expected 1/0010/4d",
                               gnt_id, req_ready, uart_data);
        end
        req_valid = '0;
        wait_done(60, dv);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wrap_skip();
        test_timeout();
        test_busy_xcvr();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
